// File: rtl/imem_loader_pkg.sv
// Shared state encoding and framing constants for the imem byte-stream loader.
// Optional checksum stage is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_HDR  = 3'd1;
  localparam state_t S_LOAD = 3'd2;
  localparam state_t S_CHK  = 3'd3;
  localparam state_t S_ERR  = 3'd4;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a big-endian byte stream into words; word_valid pulses the cycle
// after the last byte of each word has been shifted in.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [1:0]        cnt,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic              wv_q, wv_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    wv_d  = 1'b0;
    if (clr) begin
      cnt_d = 2'd0;
    end else if (byte_valid) begin
      sr_d  = {sr_q[WORD_W-9:0], byte_data};
      cnt_d = cnt_q + 2'd1;
      wv_d  = (cnt_q == 2'(BYTES_PER_WORD - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 2'd0;
      sr_q  <= '0;
      wv_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
      wv_q  <= wv_d;
    end
  end

  assign cnt        = cnt_q;
  assign word       = sr_q;
  assign word_valid = wv_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: header length, payload words to imem, core held meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int WORD_W    = 32,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic              hdr_idx_q, hdr_idx_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic        xfer, pk_clr, pk_vld, fin;
  logic [1:0]  pk_cnt;
  logic [15:0] hdr_len, wnext;

  assign in_ready = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
  assign xfer     = in_valid & in_ready;
  assign pk_clr   = start & ((state_q == S_IDLE) || (state_q == S_ERR));
  assign pk_vld   = xfer & (state_q == S_LOAD);
  assign hdr_len  = {len_q[15:8], in_data};
  assign wnext    = 16'(wcnt_q) + 16'd1;

  byte_packer #(.WORD_W(WORD_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_valid (pk_vld),
    .byte_data  (in_data),
    .cnt        (pk_cnt),
    .word       (wr_data),
    .word_valid (wr_en)
  );

  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    wr_addr_d = wr_addr_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    fin       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d   = S_HDR;
          hdr_idx_d = 1'b0;
          wcnt_d    = '0;
          hold_d    = 1'b1;
          busy_d    = 1'b1;
          err_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d     = 8'h00;
`endif
        end
      end
      S_HDR: begin
        if (xfer) begin
          if (hdr_idx_q != 1'(HDR_BYTES - 1)) begin
            len_d     = {in_data, 8'h00};
            hdr_idx_d = 1'b1;
          end else begin
            len_d = hdr_len;
            if (hdr_len == 16'd0) begin
              fin = 1'b1;
            end else if (hdr_len > 16'(MAX_WORDS)) begin
              state_d = S_ERR;
              err_d   = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ in_data;
`endif
          // Address is latched with the completing byte so it is stable during the strobe.
          if (pk_cnt == 2'(BYTES_PER_WORD - 1)) begin
            wr_addr_d = wcnt_q[ADDR_W-1:0];
            wcnt_d    = wcnt_q + 1'b1;
            fin       = (wnext == len_q);
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          if (in_data == xor_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      state_d = S_CHK;
`else
      state_d = S_IDLE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      hold_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      hdr_idx_q <= 1'b0;
      len_q     <= '0;
      wcnt_q    <= '0;
      wr_addr_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      wr_addr_q <= wr_addr_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  assign wr_addr   = wr_addr_q;
  assign core_hold = hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
